quadrature_decoder: RTL

//   Converts the two debounced quadrature channels of a rotary encoder into

---
 rtl/quadrature_decoder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: debounced A/B channels to detent steps plus a position counter.
// Define QUAD_SATURATE_EN to make the counter saturate at signed max/min instead of wrapping.
module quadrature_decoder #(
    parameter int unsigned COUNT_WIDTH      = 16,
    parameter int unsigned STEPS_PER_DETENT = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enc_a,
    input  logic                   enc_b,
    input  logic                   enable,
    input  logic                   clear,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   step_valid,
    output logic                   step_dir,
    output logic                   error
);

    localparam int unsigned AccW = $clog2(STEPS_PER_DETENT) + 2;
    localparam logic signed [AccW-1:0] AccMax = $signed(AccW'(STEPS_PER_DETENT - 1));
    localparam logic signed [AccW-1:0] AccMin = -AccMax;
    localparam logic signed [AccW-1:0] AccOne = $signed(AccW'(1));
    localparam logic [COUNT_WIDTH-1:0] CountMax = {1'b0, {(COUNT_WIDTH - 1) {1'b1}}};
    localparam logic [COUNT_WIDTH-1:0] CountMin = {1'b1, {(COUNT_WIDTH - 1) {1'b0}}};
    localparam logic [COUNT_WIDTH-1:0] CountOne = COUNT_WIDTH'(1);

    logic                   armed_q, armed_d;
    logic [1:0]             prev_ab_q, prev_ab_d;
    logic signed [AccW-1:0] acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   step_valid_q, step_valid_d;
    logic                   step_dir_q, step_dir_d;
    logic                   error_q, error_d;

    logic [1:0]             cur_ab;
    logic                   sub_cw, sub_ccw, both_flip;
    logic [COUNT_WIDTH-1:0] count_up, count_down;

    // Successor of a phase in the clockwise Gray sequence 00->01->11->10->00.
    function automatic logic [1:0] cw_next(input logic [1:0] ab);
        unique case (ab)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    assign cur_ab    = {enc_a, enc_b};
    assign sub_cw    = (cur_ab == cw_next(prev_ab_q));
    assign sub_ccw   = (prev_ab_q == cw_next(cur_ab));
    assign both_flip = ((cur_ab ^ prev_ab_q) == 2'b11);

`ifdef QUAD_SATURATE_EN
    assign count_up   = (count_q == CountMax) ? count_q : count_q + CountOne;
    assign count_down = (count_q == CountMin) ? count_q : count_q - CountOne;
`else
    assign count_up   = count_q + CountOne;
    assign count_down = count_q - CountOne;
`endif

    always_comb begin
        armed_d      = 1'b1;
        prev_ab_d    = cur_ab;
        acc_d        = acc_q;
        count_d      = count_q;
        step_valid_d = 1'b0;
        step_dir_d   = step_dir_q;
        error_d      = 1'b0;

        // The arming edge only captures the phase, so no step is reported out of reset.
        if (armed_q) begin
            if (both_flip) begin
                error_d = 1'b1;
                acc_d   = '0;
            end else if (enable && sub_cw) begin
                if (acc_q == AccMax) begin
                    acc_d        = '0;
                    step_valid_d = 1'b1;
                    step_dir_d   = 1'b1;
                    count_d      = count_up;
                end else begin
                    acc_d = acc_q + AccOne;
                end
            end else if (enable && sub_ccw) begin
                if (acc_q == AccMin) begin
                    acc_d        = '0;
                    step_valid_d = 1'b1;
                    step_dir_d   = 1'b0;
                    count_d      = count_down;
                end else begin
                    acc_d = acc_q - AccOne;
                end
            end
        end

        // Clear overrides a step completing in the same cycle.
        if (clear) begin
            count_d      = '0;
            acc_d        = '0;
            step_valid_d = 1'b0;
            step_dir_d   = step_dir_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_q      <= 1'b0;
            prev_ab_q    <= 2'b00;
            acc_q        <= '0;
            count_q      <= '0;
            step_valid_q <= 1'b0;
            step_dir_q   <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            armed_q      <= armed_d;
            prev_ab_q    <= prev_ab_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            step_valid_q <= step_valid_d;
            step_dir_q   <= step_dir_d;
            error_q      <= error_d;
        end
    end

    assign count      = count_q;
    assign step_valid = step_valid_q;
    assign step_dir   = step_dir_q;
    assign error      = error_q;

endmodule
